// File: rtl/oldland_bus_pkg.sv
// Shared definitions for Oldland data-bus targets: handshake states, counter
// width, byte-lane geometry and address split helpers.
package oldland_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_TURN
  } bus_state_e;

  localparam int CNT_W     = 4;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  function automatic logic [29:0] word_addr(input logic [31:0] a);
    return a[31:2];
  endfunction

  function automatic logic [1:0] byte_off(input logic [31:0] a);
    return a[1:0];
  endfunction

endpackage

// File: rtl/oldland_byte_ram.sv
// Word RAM built from independent byte lanes: synchronous read, per-lane write
// enables, read data registered on every enabled access.
module oldland_byte_ram
  import oldland_bus_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 10
) (
  input  logic                              clk,
  input  logic                              en_i,
  input  logic [NUM_LANES-1:0]              we_i,
  input  logic [ADDR_WORDS_LOG2-1:0]        addr_i,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  wdata_i,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  rdata_o
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] mem_q [0:(1<<ADDR_WORDS_LOG2)-1];
    logic [LANE_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (en_i) begin
        if (we_i[l]) mem_q[addr_i] <= wdata_i[l];
        rd_q <= mem_q[addr_i];
      end
    end

    assign rdata_o[l] = rd_q;
  end

endmodule

// File: rtl/oldland_sram_target.sv
// Oldland d_* bus target: on-chip byte-writable RAM with programmable wait states.
// Define OLDLAND_SRAM_RANGE_CHECK_EN to decode BASE_ADDR and error on misses.
module oldland_sram_target
  import oldland_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h2000_0000,
  parameter int          ADDR_WORDS_LOG2 = 10,
  parameter int          WAIT_CYCLES     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  input  logic        d_access,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  bus_state_e state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       hit_q, wr_q;
  logic [NUM_LANES-1:0]       bs_q;
  logic [31:0]                wv_q;
  logic [ADDR_WORDS_LOG2-1:0] idx_q;
  logic                       ack_q, rd_q;

  logic [29:0]                wa;
  logic [ADDR_WORDS_LOG2-1:0] idx_in;
  logic                       hit_in;
  logic                       fire;
  logic                       op_hit, op_wr;
  logic [NUM_LANES-1:0]       op_bs;
  logic [31:0]                op_wv;
  logic [ADDR_WORDS_LOG2-1:0] op_idx;
  logic [NUM_LANES-1:0][LANE_W-1:0] ram_rdata;
  logic                       unused_ok;

  assign wa     = word_addr(d_addr);
  assign idx_in = wa[ADDR_WORDS_LOG2-1:0];

`ifdef OLDLAND_SRAM_RANGE_CHECK_EN
  localparam logic [29:0] BASE_TAG = word_addr(BASE_ADDR) >> ADDR_WORDS_LOG2;
  logic err_q;

  assign hit_in    = ((wa >> ADDR_WORDS_LOG2) == BASE_TAG);
  assign d_error   = err_q;
  assign unused_ok = ^{byte_off(d_addr)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= fire & ~op_hit;
  end
`else
  assign hit_in    = 1'b1;
  assign d_error   = 1'b0;
  assign unused_ok = ^{byte_off(d_addr), wa[29:ADDR_WORDS_LOG2], BASE_ADDR};
`endif

  // With zero wait states the RAM is accessed at the capture edge itself,
  // so the live bus values stand in for the not-yet-loaded capture registers.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_hit = hit_in;
      op_wr  = d_wr_en;
      op_bs  = d_bytesel;
      op_wv  = d_wr_val;
      op_idx = idx_in;
    end else begin
      op_hit = hit_q;
      op_wr  = wr_q;
      op_bs  = bs_q;
      op_wv  = wv_q;
      op_idx = idx_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_access) begin
          cnt_d = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            fire    = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          fire    = 1'b1;
        end
      end
      ST_RESP: state_d = ST_TURN;
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      wr_q    <= 1'b0;
      bs_q    <= '0;
      wv_q    <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && d_access) begin
        hit_q <= hit_in;
        wr_q  <= d_wr_en;
        bs_q  <= d_bytesel;
        wv_q  <= d_wr_val;
        idx_q <= idx_in;
      end
      ack_q <= fire & op_hit;
      rd_q  <= fire & op_hit & ~op_wr;
    end
  end

  oldland_byte_ram #(
    .ADDR_WORDS_LOG2(ADDR_WORDS_LOG2)
  ) u_ram (
    .clk    (clk),
    .en_i   (fire & op_hit),
    .we_i   (op_wr ? op_bs : '0),
    .addr_i (op_idx),
    .wdata_i(op_wv),
    .rdata_o(ram_rdata)
  );

  // RAM output register only reaches the bus during a load ack.
  assign d_data = rd_q ? ram_rdata : '0;
  assign d_ack  = ack_q;

endmodule

// File: doc/oldland_sram_target.md
# oldland_sram_target

Data-bus responder for the Oldland CPU: the target end of the `d_*` data interface driven by the CPU's memory stage. It holds a byte-writable on-chip word RAM mapped at a fixed base address. It services one load or store at a time, with a programmable number of wait states, and returns a single-cycle ack, or an error for out-of-range addresses. It sits between the CPU data port and the system bus fabric, and is the primary test target for the memory stage's stall/complete logic.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h2000_0000: byte address of word 0; must be aligned to the RAM size.
- `ADDR_WORDS_LOG2`, default 10: RAM depth is 2^ADDR_WORDS_LOG2 32-bit words (default 4 KiB).
- `WAIT_CYCLES`, default 1: extra cycles between request capture and ack; legal range 0..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `d_addr` in 32: byte address; bits [1:0] ignored (word access).
- `d_bytesel` in 4: byte-lane enables; bit n covers d_wr_val[8n+7:8n].
- `d_wr_en` in 1: 1 = store, 0 = load.
- `d_wr_val` in 32: store data.
- `d_access` in 1: request, held high by the initiator until it sees `d_ack` or `d_error`.
- `d_data` out 32: load data; valid only while `d_ack` is high, 0 otherwise.
- `d_ack` out 1: one-cycle completion pulse.
- `d_error` out 1: one-cycle error pulse, mutually exclusive with `d_ack`.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - RESP: `d_ack` or `d_error` high.
  - TURN: one dead cycle.
- IDLE:
  - On `d_access`=1, register addr, bytesel, wr_en and wr_val.
  - Register hit = (addr[31:ADDR_WORDS_LOG2+2] == BASE_ADDR[31:ADDR_WORDS_LOG2+2]).
  - Load wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
  - Bus inputs are ignored; the captured values are used.
- Entering RESP, at the same edge:
  - Hit and store: write the enabled byte lanes of word addr[ADDR_WORDS_LOG2+1:2]. bytesel=0 is a legal no-op store.
  - Hit and load: register the full word onto `d_data`.
  - Set `d_ack`=1.
  - Miss: set `d_error`=1, `d_data`=0, no write.
- RESP: lasts exactly one cycle, then TURN.
- TURN:
  - `d_access` is ignored.
  - Outputs are 0.
  - Next state is IDLE.
  - Guarantees the initiator one registered cycle to drop `d_access` after seeing ack, so one request is never serviced twice.
- Reset (asynchronous, any state):
  - Go to IDLE; `d_ack`=0, `d_error`=0, `d_data`=0, counter=0.
  - A store aborted before entering RESP is not written.
  - RAM contents are not reset.

## Timing
- Request high in cycle 0 while in IDLE → ack/error high in cycle 1+WAIT_CYCLES.
- TURN occupies cycle 2+WAIT_CYCLES.
- The next request is accepted at the earliest in cycle 3+WAIT_CYCLES.
- Throughput is one transaction per 3+WAIT_CYCLES cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A store's written data is visible to a load issued in the next transaction.

## Configuration
- `OLDLAND_SRAM_RANGE_CHECK_EN` defined:
  - Address decode as above.
  - Misses return `d_error` and have no side effects.
- Not defined:
  - No decode; every access is a hit.
  - The word index is addr[ADDR_WORDS_LOG2+1:2], so addresses alias modulo the RAM size.
  - `d_error` is constant 0.

## Structure
- Shared package `oldland_bus_pkg`:
  - State enum (IDLE/WAIT/RESP/TURN).
  - Wait-counter width constant (4).
  - Byte-lane count constant (4).
  - Word/byte address split helpers, also used by future bus targets.
- Sub-module `oldland_byte_ram`:
  - Depth 2^ADDR_WORDS_LOG2 × 32.
  - Synchronous read, per-byte write enables.
  - Instantiated once.
- Top level: FSM, capture registers, decode, output registers.

## Test plan
- WAIT_CYCLES=1: store 32'hDEADBEEF to 32'h2000_0010 with bytesel 4'hF → `d_ack` in cycle 2, `d_error`=0. A following load of the same address → `d_data`=32'hDEADBEEF during the ack cycle, 0 in the cycles before and after.
- Byte-lane merge: over word 32'h11223344, store 32'hAABBCCDD with bytesel 4'b0101 → reload returns 32'h11BB33DD.
- WAIT_CYCLES=0 and WAIT_CYCLES=15: ack arrives exactly 1 and 16 cycles after request capture. With `d_access` held high through TURN, exactly one ack is produced per request.
- With the macro defined: load from 32'h3000_0000 → `d_error` for one cycle, `d_ack`=0, `d_data`=0. A store to the same address leaves RAM word 0 unchanged.
- Without the macro: store 32'h5A5A5A5A to 32'h2000_1000 (default depth) → a load from 32'h2000_0000 returns 32'h5A5A5A5A, and `d_error` is never asserted.
- Reset asserted mid-WAIT of a store (WAIT_CYCLES=4):
  - Outputs go to 0 immediately.
  - No ack is produced.
  - The target word keeps its old value.
  - After `rst_n` rises, a new request completes normally.
